qsfp_mgmt_ctrl: RTL



---
 rtl/qsfp_mgmt_ctrl_if.sv | 20 ++
 rtl/qsfp_mgmt_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qsfp_mgmt_ctrl_if.sv
// Wishbone slave bus bundle for the QSFP+ management controller.
interface qsfp_mgmt_ctrl_if;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we;
  logic        wb_stb;
  logic        wb_cyc;
  logic        wb_ack;

  modport master (
    output wb_adr, wb_dat_i, wb_we, wb_stb, wb_cyc,
    input  wb_dat_o, wb_ack
  );

  modport slave (
    input  wb_adr, wb_dat_i, wb_we, wb_stb, wb_cyc,
    output wb_dat_o, wb_ack
  );
endinterface

// File: rtl/qsfp_mgmt_ctrl.sv
// Hot-plug, module-select and interrupt management for NUM_PORTS QSFP+ cages.
// Optional per-port interrupt counters enabled by defining QSFP_MGMT_ERRCNT_EN.
module qsfp_mgmt_ctrl #(
  parameter int unsigned NUM_PORTS       = 1,
  parameter int unsigned RESET_CYCLES    = 2000,
  parameter int unsigned INIT_CYCLES     = 400000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  qsfp_mgmt_ctrl_if.slave      wb,
  output logic [NUM_PORTS-1:0] qsfp_modsel_b,
  output logic [NUM_PORTS-1:0] qsfp_reset_b,
  output logic [NUM_PORTS-1:0] qsfp_lp_mode,
  input  logic [NUM_PORTS-1:0] qsfp_modprs_b,
  input  logic [NUM_PORTS-1:0] qsfp_int_b,
  output logic [NUM_PORTS-1:0] ready,
  output logic                 irq
);

  localparam logic [1:0] ST_ABSENT = 2'd0;
  localparam logic [1:0] ST_RESET  = 2'd1;
  localparam logic [1:0] ST_INIT   = 2'd2;
  localparam logic [1:0] ST_READY  = 2'd3;

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES);
  localparam logic [31:0]   RST_LOAD  = 32'(RESET_CYCLES - 1);
  localparam logic [31:0]   INIT_LOAD = 32'(INIT_CYCLES - 1);

  logic [NUM_PORTS-1:0] prs_s1_q, prs_s2_q, prs_s3_q;
  logic [NUM_PORTS-1:0] int_s1_q, int_s2_q, int_s3_q;

  logic [DW-1:0] deb_cnt_q [NUM_PORTS];
  logic [DW-1:0] deb_cnt_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] present_q, present_d;

  logic [1:0]  state_q [NUM_PORTS];
  logic [1:0]  state_d [NUM_PORTS];
  logic [31:0] tmr_q   [NUM_PORTS];
  logic [31:0] tmr_d   [NUM_PORTS];

  logic [3:0]             sel_idx_q, sel_idx_d;
  logic                   sel_en_q, sel_en_d;
  logic [NUM_PORTS-1:0]   lp_mode_q, lp_mode_d;
  logic [NUM_PORTS-1:0]   int_ev_q, int_ev_d;
  logic [NUM_PORTS-1:0]   prs_ev_q, prs_ev_d;
  logic [2*NUM_PORTS-1:0] irq_mask_q, irq_mask_d;
  logic                   irq_q, irq_d;
  logic                   ack_q, ack_d;
  logic [31:0]            dat_o_q, dat_o_d;

  logic                   req, wr;
  logic [7:0]             adr;
  logic [NUM_PORTS-1:0]   rst_req, int_set, int_clr, prs_clr, ready_vec;
  logic [2*NUM_PORTS-1:0] state_vec;
  logic [31:0]            rd_data;
  logic                   unused_wb;

  assign req       = wb.wb_cyc & wb.wb_stb & ~ack_q;
  assign wr        = req & wb.wb_we;
  assign adr       = wb.wb_adr[7:0];
  assign unused_wb = ^{wb.wb_adr[31:8], wb.wb_dat_i};

  assign rst_req = (wr && adr == 8'h03) ? wb.wb_dat_i[NUM_PORTS-1:0] : '0;
  assign int_clr = (wr && adr == 8'h06) ? wb.wb_dat_i[NUM_PORTS-1:0] : '0;
  assign prs_clr = (wr && adr == 8'h07) ? wb.wb_dat_i[NUM_PORTS-1:0] : '0;
  assign int_set = int_s3_q & ~int_s2_q & present_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prs_s1_q <= '1;
      prs_s2_q <= '1;
      prs_s3_q <= '1;
      int_s1_q <= '1;
      int_s2_q <= '1;
      int_s3_q <= '1;
    end else begin
      prs_s1_q <= qsfp_modprs_b;
      prs_s2_q <= prs_s1_q;
      prs_s3_q <= prs_s2_q;
      int_s1_q <= qsfp_int_b;
      int_s2_q <= int_s1_q;
      int_s3_q <= int_s2_q;
    end
  end

  // prs_s3_q is the value held stable while the counter ran, so it is what gets adopted.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    present_d = present_q;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (prs_s2_q[i] != prs_s3_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] != DEB_MAX) begin
        deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
      end
      if (deb_cnt_q[i] == DEB_MAX) begin
        present_d[i] = ~prs_s3_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!present_q[i]) begin
        state_d[i] = ST_ABSENT;
      end else if (rst_req[i] && state_q[i] != ST_ABSENT) begin
        state_d[i] = ST_RESET;
        tmr_d[i]   = RST_LOAD;
      end else begin
        case (state_q[i])
          ST_ABSENT: begin
            state_d[i] = ST_RESET;
            tmr_d[i]   = RST_LOAD;
          end
          ST_RESET: begin
            if (tmr_q[i] == '0) begin
              state_d[i] = ST_INIT;
              tmr_d[i]   = INIT_LOAD;
            end else begin
              tmr_d[i] = tmr_q[i] - 32'd1;
            end
          end
          ST_INIT: begin
            if (tmr_q[i] == '0) begin
              state_d[i] = ST_READY;
            end else begin
              tmr_d[i] = tmr_q[i] - 32'd1;
            end
          end
          default: state_d[i] = ST_READY;
        endcase
      end
    end
  end

  always_comb begin
    ready_vec     = '0;
    qsfp_reset_b  = '0;
    qsfp_modsel_b = '1;
    state_vec     = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      ready_vec[i]       = (state_q[i] == ST_READY);
      qsfp_reset_b[i]    = (state_q[i] == ST_INIT) || (state_q[i] == ST_READY);
      qsfp_modsel_b[i]   = ~(sel_en_q && sel_idx_q == 4'(i));
      state_vec[2*i +: 2] = state_q[i];
    end
  end

  always_comb begin
    sel_idx_d  = sel_idx_q;
    sel_en_d   = sel_en_q;
    lp_mode_d  = lp_mode_q;
    irq_mask_d = irq_mask_q;
    if (wr) begin
      case (adr)
        8'h01: begin
          sel_idx_d = wb.wb_dat_i[3:0];
          sel_en_d  = wb.wb_dat_i[4];
        end
        8'h02:   lp_mode_d  = wb.wb_dat_i[NUM_PORTS-1:0];
        8'h08:   irq_mask_d = wb.wb_dat_i[2*NUM_PORTS-1:0];
        default: ;
      endcase
    end
    // Set terms are OR-ed after the clear so a coincident event is not lost.
    int_ev_d = (int_ev_q & ~int_clr) | int_set;
    prs_ev_d = (prs_ev_q & ~prs_clr) | (present_d ^ present_q);
    irq_d    = |({prs_ev_q, int_ev_q} & irq_mask_q);
  end

`ifdef QSFP_MGMT_ERRCNT_EN
  logic [15:0] errcnt_q [NUM_PORTS];
  logic [15:0] errcnt_d [NUM_PORTS];

  always_comb begin
    errcnt_d = errcnt_q;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (wr && adr == 8'(16 + i)) begin
        errcnt_d[i] = int_set[i] ? 16'd1 : 16'd0;
      end else if (int_set[i] && errcnt_q[i] != '1) begin
        errcnt_d[i] = errcnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) errcnt_q[i] <= '0;
    end else begin
      errcnt_q <= errcnt_d;
    end
  end
`endif

  always_comb begin
    rd_data = '0;
    case (adr)
      8'h00:   rd_data = {16'h51F0, 8'd0, 8'(NUM_PORTS)};
      8'h01:   rd_data = {27'd0, sel_en_q, sel_idx_q};
      8'h02:   rd_data = 32'(lp_mode_q);
      8'h04:   rd_data = 32'(present_q);
      8'h05:   rd_data = 32'(ready_vec);
      8'h06:   rd_data = 32'(int_ev_q);
      8'h07:   rd_data = 32'(prs_ev_q);
      8'h08:   rd_data = 32'(irq_mask_q);
      8'h09:   rd_data = 32'(state_vec);
      default: rd_data = '0;
    endcase
`ifdef QSFP_MGMT_ERRCNT_EN
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (adr == 8'(16 + i)) rd_data = {16'd0, errcnt_q[i]};
    end
`endif
    ack_d   = wb.wb_cyc & wb.wb_stb & ~ack_q;
    dat_o_d = (req && !wb.wb_we) ? rd_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        deb_cnt_q[i] <= '0;
        state_q[i]   <= ST_ABSENT;
        tmr_q[i]     <= '0;
      end
      present_q  <= '0;
      sel_idx_q  <= '0;
      sel_en_q   <= 1'b0;
      lp_mode_q  <= '1;
      int_ev_q   <= '0;
      prs_ev_q   <= '0;
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
      ack_q      <= 1'b0;
      dat_o_q    <= '0;
    end else begin
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      present_q  <= present_d;
      sel_idx_q  <= sel_idx_d;
      sel_en_q   <= sel_en_d;
      lp_mode_q  <= lp_mode_d;
      int_ev_q   <= int_ev_d;
      prs_ev_q   <= prs_ev_d;
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
      ack_q      <= ack_d;
      dat_o_q    <= dat_o_d;
    end
  end

  assign qsfp_lp_mode = lp_mode_q;
  assign ready        = ready_vec;
  assign irq          = irq_q;
  assign wb.wb_ack    = ack_q;
  assign wb.wb_dat_o  = dat_o_q;

endmodule
